// File: rtl/noc_rx_port_if.sv
// Router-to-router receive link: upstream flit delivery plus the core-side drain port.
interface noc_rx_port_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CAP_W  = 3
);
    logic [DATA_W-1:0] data_in;
    logic              write_in_signal;
    logic [CAP_W-1:0]  capacity_out;
    logic              ack_out;
    logic [DATA_W-1:0] data_out;
    logic              ready_out;
    logic              next_in;

    // Receive port side
    modport slave (
        input  data_in,
        input  write_in_signal,
        input  next_in,
        output capacity_out,
        output ack_out,
        output data_out,
        output ready_out
    );

    // Sender / router-core side
    modport master (
        output data_in,
        output write_in_signal,
        output next_in,
        input  capacity_out,
        input  ack_out,
        input  data_out,
        input  ready_out
    );
endinterface

// File: rtl/noc_rx_port.sv
// Router input port: packet-committing flit FIFO with free-space report and per-packet ack.
// Flits of a packet are written tentatively at wr_ptr and only become visible to the
// router core once the final flit arrives and cm_ptr jumps forward.
module noc_rx_port #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_PKT  = 5,
    parameter int unsigned SIZE_LSB = 0,
    parameter int unsigned SIZE_W   = 3,
    parameter int unsigned TIMEOUT  = 4
) (
    input  logic          clock,
    input  logic          reset,
    noc_rx_port_if.slave  link
);
    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned IW      = $clog2(TIMEOUT + 1);
    localparam int unsigned CW      = ((SIZE_W > PW) ? SIZE_W : PW) + 1;
    localparam int unsigned CAP_W   = 3;
    localparam int unsigned CAP_MAX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     mem [DEPTH];
    logic [PW-1:0]     rd_ptr, cm_ptr, wr_ptr;
    logic [PW-1:0]     cm_ptr_nxt, wr_ptr_nxt;
    logic [SIZE_W-1:0] rem, rem_nxt;
    logic [SIZE_W-1:0] drop, drop_nxt;
    logic [IW-1:0]     idle_cnt, idle_nxt;
    logic              ack, ack_nxt;
    logic              store;
    logic              pop;
    logic              timed_out;
    logic              hdr_ok;
    logic [PW-1:0]     occupancy;
    logic [PW-1:0]     free_slots;
    logic [SIZE_W-1:0] hdr_size;

    // Occupancy counts tentative flits so a packet in flight reserves its space
    assign occupancy  = wr_ptr - rd_ptr;
    assign free_slots = PW'(DEPTH) - occupancy;
    assign hdr_size   = link.data_in[SIZE_LSB +: SIZE_W];
    assign hdr_ok     = (hdr_size != '0)
                     && (CW'(hdr_size) <= CW'(MAX_PKT))
                     && (CW'(hdr_size) <= CW'(free_slots));
    assign timed_out  = (idle_cnt == IW'(TIMEOUT - 1));
    assign pop        = link.next_in && (cm_ptr != rd_ptr);

    // Outputs derived from registers only
    assign link.ready_out    = (cm_ptr != rd_ptr);
    assign link.data_out     = mem[rd_ptr[AW-1:0]];
    assign link.capacity_out = (CW'(free_slots) > CW'(CAP_MAX)) ? CAP_W'(CAP_MAX)
                                                                 : CAP_W'(free_slots);
    assign link.ack_out      = ack;

    // Next-state and write-side control for header accept, packet receive and drop
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        cm_ptr_nxt = cm_ptr;
        rem_nxt    = rem;
        drop_nxt   = drop;
        idle_nxt   = idle_cnt;
        ack_nxt    = ack;
        store      = 1'b0;

        case (state)
            IDLE: begin
                idle_nxt = '0;
                if (link.write_in_signal) begin
                    ack_nxt = 1'b0;
                    if (hdr_ok) begin
                        store      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        rem_nxt    = hdr_size - SIZE_W'(1);
                        if (hdr_size == SIZE_W'(1)) begin
                            cm_ptr_nxt = wr_ptr + PW'(1);
                            ack_nxt    = 1'b1;
                        end else begin
                            state_nxt = RECV;
                        end
                    end else begin
                        drop_nxt = (hdr_size == '0) ? '0 : hdr_size - SIZE_W'(1);
                        if (hdr_size > SIZE_W'(1)) begin
                            state_nxt = DROP;
                        end
                    end
                end
            end

            RECV: begin
                if (link.write_in_signal) begin
                    store      = 1'b1;
                    wr_ptr_nxt = wr_ptr + PW'(1);
                    idle_nxt   = '0;
                    if (rem == SIZE_W'(1)) begin
                        cm_ptr_nxt = wr_ptr + PW'(1);
                        ack_nxt    = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        rem_nxt = rem - SIZE_W'(1);
                    end
                end else if (timed_out) begin
                    // Sender stalled: discard the partial packet, sender retransmits
                    wr_ptr_nxt = cm_ptr;
                    idle_nxt   = '0;
                    state_nxt  = IDLE;
                end else begin
                    idle_nxt = idle_cnt + IW'(1);
                end
            end

            DROP: begin
                if (link.write_in_signal) begin
                    idle_nxt = '0;
                    drop_nxt = drop - SIZE_W'(1);
                    if (drop == SIZE_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end else if (timed_out) begin
                    idle_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    idle_nxt = idle_cnt + IW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            cm_ptr   <= '0;
            wr_ptr   <= '0;
            rem      <= '0;
            drop     <= '0;
            idle_cnt <= '0;
            ack      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_ptr   <= rd_ptr + PW'(pop);
            cm_ptr   <= cm_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rem      <= rem_nxt;
            drop     <= drop_nxt;
            idle_cnt <= idle_nxt;
            ack      <= ack_nxt;
        end
    end

    // Flit storage; cleared on reset so the show-ahead output starts at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store) begin
            mem[wr_ptr[AW-1:0]] <= link.data_in;
        end
    end
endmodule
